elevator_3_floor_ctrl: RTL and testbench
========================================

Name: elevator_3_floor_ctrl

Overview:
- Controller for a three-floor elevator car.
- Takes call buttons, per-floor position sensors and an overweight sensor; drives up/down motor commands, one seven-segment digit and four status LEDs.
- Detects sensor inconsistencies and locks into a fault state that only reset clears.
- Sits between the board I/O (buttons, limit sensors, display) and the motor driver.

Parameters:
- TIMEOUT, 1024: maximum clock cycles allowed in a MOVING state without reaching the target floor before a fault is raised.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- p1  in  1  call button, floor 1; level, active-high.
- p2  in  1  call button, floor 2; level, active-high.
- p3  in  1  call button, floor 3; level, active-high.
- f1  in  1  floor-1 position sensor; high while the car is at floor 1.
- f2  in  1  floor-2 position sensor; high while the car is at floor 2.
- f3  in  1  floor-3 position sensor; high while the car is at floor 3.
- s  in  1  overweight sensor; high means overloaded.
- mup  out  1  motor up command.
- mdw  out  1  motor down command.
- D_out  out  7  seven-segment pattern {g,f,e,d,c,b,a}, active-low.
- E_dis  out  4  digit enables, active-low.
- led  out  4  status LEDs, active-high.

Behaviour:
- Input conditioning:
  - All of p1..p3, f1..f3 and s pass through 2-flop synchronizers.
  - Decisions use the synchronized values, so response latency from an input pin to a registered output is 3 cycles.
  - All outputs are registered.
- Reset (reset=0, asynchronous):
  - mup=0, mdw=0, led=4'b0000, E_dis=4'b1110, D_out="-" (7'b0111111).
  - Target register cleared; FSM enters INIT.
- FSM states: INIT, UNKNOWN, IDLE, MOVING_UP, MOVING_DOWN, FAULT.
- INIT (one cycle after reset release): evaluate the sensors.
  - Exactly one sensor high -> IDLE with floor = that sensor.
  - No sensor high -> UNKNOWN.
  - More than one high -> FAULT.
- UNKNOWN:
  - Motors off; display "-".
  - Any call with s=0 -> MOVING_DOWN with target = lowest pressed floor.
  - While in MOVING_DOWN from UNKNOWN, the first sensor to assert sets the floor.
  - If that sensor equals the target -> IDLE; if it is above the target -> continue down.
  - If it is below the target -> FAULT.
- IDLE:
  - Motors off.
  - Accept a call only when s=0; priority p1>p2>p3; a call to the current floor is ignored.
  - Target above floor -> MOVING_UP; target below -> MOVING_DOWN.
  - With s=1 all calls are ignored; calls are not latched, so a button released while s=1 is lost.
  - Fault conditions:
    - any sensor other than the current floor's asserts -> FAULT;
    - more than one sensor high -> FAULT.
  - The current floor's sensor dropping with none other high is tolerated; the car stays IDLE.
- MOVING_UP / MOVING_DOWN:
  - mup=1 or mdw=1 respectively; never both.
  - s is ignored while moving.
  - Sensor of the floor just left may stay high; the intermediate floor 2 (1<->3 trips) updates the displayed floor.
  - Target sensor asserting -> IDLE at target; the motor deasserts on the next registered update.
  - Fault conditions:
    - a sensor beyond the target in the travel direction asserts;
    - a sensor behind the start floor asserts;
    - two or more sensors are high at once;
    - the cycle counter reaches TIMEOUT.
  - Each of these -> FAULT.
- FAULT:
  - mup=mdw=0 and display "E" (7'b0000110).
  - All inputs ignored; exits only via reset.
- Display:
  - E_dis fixed at 4'b1110 (digit 0 only).
  - D_out shows the current floor: "1"=7'b1111001, "2"=7'b0100100, "3"=7'b0110000.
  - Shows "-" in UNKNOWN and "E" in FAULT.
- LEDs:
  - led[0]=mup, led[1]=mdw.
  - led[2]=synchronized s.
  - led[3]=FAULT state.
- Invariant: mup & mdw is never 1.

Test Plan:
- Reset with f1=1, s=1, pulse p1/p2/p3 for 4 cycles each -> mup=mdw=0 throughout, led[2]=1, D_out="1".
- At floor 1, s=0, pulse p2, then drop f1 and raise f3 -> mup=1 after 3 cycles; on f3, FAULT: mup=0, D_out="E", led[3]=1; persists until reset.
- Reset with no sensors -> D_out="-", motors off. Pulse p1 -> mdw=1; raise f1 -> mdw=0, D_out="1". Then raise f2 -> FAULT.
- Reset at f3, pulse p2 -> mdw=1; drop f3, raise f1 (beyond target) -> FAULT, mdw=0.
- Reset at f2, then raise f1 while idle -> FAULT. Pulse reset low mid-FAULT -> outputs return to reset values immediately (asynchronously).
- Floor 1 -> 3 normal trip: pulse p3, f2 passes (D_out shows "2", mup stays 1), f3 asserts -> mup=0, D_out="3". Separately hold the target sensor low for TIMEOUT cycles -> FAULT.

Source files
------------

// File: rtl/elevator_3_floor_ctrl.sv
// Three-floor elevator controller: synchronized inputs, one FSM with registered motor,
// display and LED outputs, and a sticky FAULT state that only reset clears.
module elevator_3_floor_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1,
    input  logic       p2,
    input  logic       p3,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    input  logic       s,
    output logic       mup,
    output logic       mdw,
    output logic [6:0] D_out,
    output logic [3:0] E_dis,
    output logic [3:0] led
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_E    = 7'b0000110;

    typedef enum logic [2:0] {INIT, UNKNOWN, IDLE, MOVING_UP, MOVING_DOWN, FAULT} state_t;

    function automatic logic [2:0] onehot(input logic [1:0] fl);
        case (fl)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] above(input logic [1:0] fl);
        case (fl)
            2'd1:    return 3'b110;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] below(input logic [1:0] fl);
        case (fl)
            2'd2:    return 3'b001;
            2'd3:    return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Lowest set bit as a floor number; 0 means none.
    function automatic logic [1:0] encode(input logic [2:0] v);
        if (v[0])      return 2'd1;
        else if (v[1]) return 2'd2;
        else if (v[2]) return 2'd3;
        else           return 2'd0;
    endfunction

    function automatic logic multi(input logic [2:0] v);
        return (v & (v - 3'd1)) != 3'd0;
    endfunction

    function automatic logic [6:0] seg(input logic [1:0] fl);
        case (fl)
            2'd1:    return 7'b1111001;
            2'd2:    return 7'b0100100;
            2'd3:    return 7'b0110000;
            default: return SEG_DASH;
        endcase
    endfunction

    logic [2:0]    call_p0, call_p1, pos_p0, pos_p1;
    logic          ovl_p0, ovl_p1;
    state_t        state;
    logic [1:0]    floor, target, start;
    logic [TW-1:0] timer;
    logic          fault_led, ovl_led;

    // Stage p0/p1: two-flop synchronizers
    always_ff @(posedge clk) begin
        call_p0 <= {p3, p2, p1};
        pos_p0  <= {f3, f2, f1};
        ovl_p0  <= s;
        call_p1 <= call_p0;
        pos_p1  <= pos_p0;
        ovl_p1  <= ovl_p0;
    end

    logic          timed_out, up_fault, dn_fault, idle_fault, at_target;
    logic [2:0]    req;
    logic [1:0]    req_floor, call_floor, pos_floor;

    assign timed_out  = (timer == T_LAST);
    assign up_fault   = multi(pos_p1) || |(pos_p1 & above(target)) || |(pos_p1 & below(start)) || timed_out;
    assign dn_fault   = multi(pos_p1) || |(pos_p1 & below(target)) || |(pos_p1 & above(start)) || timed_out;
    assign idle_fault = |(pos_p1 & ~onehot(floor));
    assign at_target  = |(pos_p1 & onehot(target));
    assign req        = call_p1 & ~onehot(floor);
    assign req_floor  = encode(req);
    assign call_floor = encode(call_p1);
    assign pos_floor  = encode(pos_p1);

    assign led = {fault_led, ovl_led, mdw, mup};

    // Stage p2: FSM and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            floor     <= 2'd0;
            target    <= 2'd0;
            start     <= 2'd0;
            timer     <= '0;
            mup       <= 1'b0;
            mdw       <= 1'b0;
            D_out     <= SEG_DASH;
            E_dis     <= 4'b1110;
            fault_led <= 1'b0;
            ovl_led   <= 1'b0;
        end else begin
            E_dis   <= 4'b1110;
            ovl_led <= ovl_p1;
            case (state)
                INIT: begin
                    if (pos_p1 == 3'b000) begin
                        state <= UNKNOWN;
                        D_out <= SEG_DASH;
                    end else if (multi(pos_p1)) begin
                        state     <= FAULT;
                        D_out     <= SEG_E;
                        fault_led <= 1'b1;
                    end else begin
                        state <= IDLE;
                        floor <= pos_floor;
                        D_out <= seg(pos_floor);
                    end
                end
                UNKNOWN: begin
                    // Position unknown: descend so the first sensor seen pins the floor.
                    if (!ovl_p1 && call_p1 != 3'b000) begin
                        state  <= MOVING_DOWN;
                        target <= call_floor;
                        start  <= 2'd3;
                        timer  <= '0;
                        mdw    <= 1'b1;
                    end
                end
                IDLE: begin
                    if (idle_fault) begin
                        state     <= FAULT;
                        D_out     <= SEG_E;
                        fault_led <= 1'b1;
                    end else if (!ovl_p1 && req != 3'b000) begin
                        target <= req_floor;
                        start  <= floor;
                        timer  <= '0;
                        if (req_floor > floor) begin
                            state <= MOVING_UP;
                            mup   <= 1'b1;
                        end else begin
                            state <= MOVING_DOWN;
                            mdw   <= 1'b1;
                        end
                    end
                end
                MOVING_UP: begin
                    if (up_fault) begin
                        state     <= FAULT;
                        mup       <= 1'b0;
                        D_out     <= SEG_E;
                        fault_led <= 1'b1;
                    end else if (at_target) begin
                        state <= IDLE;
                        floor <= target;
                        mup   <= 1'b0;
                        D_out <= seg(target);
                    end else begin
                        timer <= timer + TW'(1);
                        if (pos_p1 != 3'b000) begin
                            floor <= pos_floor;
                            D_out <= seg(pos_floor);
                        end
                    end
                end
                MOVING_DOWN: begin
                    if (dn_fault) begin
                        state     <= FAULT;
                        mdw       <= 1'b0;
                        D_out     <= SEG_E;
                        fault_led <= 1'b1;
                    end else if (at_target) begin
                        state <= IDLE;
                        floor <= target;
                        mdw   <= 1'b0;
                        D_out <= seg(target);
                    end else begin
                        timer <= timer + TW'(1);
                        if (pos_p1 != 3'b000) begin
                            floor <= pos_floor;
                            D_out <= seg(pos_floor);
                        end
                    end
                end
                FAULT: begin
                    mup       <= 1'b0;
                    mdw       <= 1'b0;
                    D_out     <= SEG_E;
                    fault_led <= 1'b1;
                end
                default: begin
                    state     <= FAULT;
                    mup       <= 1'b0;
                    mdw       <= 1'b0;
                    D_out     <= SEG_E;
                    fault_led <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_3_floor_ctrl.sv
// Scoreboard bench for elevator_3_floor_ctrl: stimulus queues expected outputs tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_elevator_3_floor_ctrl;

    localparam int TIMEOUT = 1024;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_TWO   = 7'b0100100;
    localparam logic [6:0] SEG_THREE = 7'b0110000;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
    logic       f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
    logic       s = 1'b0;
    logic       mup, mdw;
    logic [6:0] d_out;
    logic [3:0] e_dis, led;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          q_at[$];
    string       q_name[$];
    logic [16:0] q_exp[$];

    elevator_3_floor_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .p1    (p1),
        .p2    (p2),
        .p3    (p3),
        .f1    (f1),
        .f2    (f2),
        .f3    (f3),
        .s     (s),
        .mup   (mup),
        .mdw   (mdw),
        .D_out (d_out),
        .E_dis (e_dis),
        .led   (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that has come due
    always @(negedge clk) begin
        int          at;
        string       nm;
        logic [16:0] ex, ac;
        while (q_at.size() > 0 && q_at[0] <= cyc) begin
            at = q_at.pop_front();
            nm = q_name.pop_front();
            ex = q_exp.pop_front();
            ac = {mup, mdw, d_out, e_dis, led};
            vectors++;
            if (at != cyc) begin
                miscompares++;
                $display("FAIL %s: check missed, due cycle %0d, now cycle %0d", nm, at, cyc);
            end else if (ac !== ex) begin
                miscompares++;
                $display("FAIL %s: got mup=%b mdw=%b D_out=%b E_dis=%b led=%b, expected mup=%b mdw=%b D_out=%b E_dis=%b led=%b",
                         nm, ac[16], ac[15], ac[14:8], ac[7:4], ac[3:0],
                         ex[16], ex[15], ex[14:8], ex[7:4], ex[3:0]);
            end
        end
        if (mup === 1'b1 && mdw === 1'b1) begin
            miscompares++;
            $display("FAIL motor_interlock: got mup=1 mdw=1 at cycle %0d, expected never both", cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int dly, input logic em, input logic ed,
                              input logic [6:0] eseg, input logic [3:0] eled);
        q_at.push_back(cyc + dly);
        q_name.push_back(name);
        q_exp.push_back({em, ed, eseg, 4'b1110, eled});
    endtask

    task automatic drain();
        int n = 0;
        while (q_at.size() > 0 && n < TIMEOUT + 100) begin
            tick(1);
            n++;
        end
        if (q_at.size() > 0) begin
            miscompares += q_at.size();
            $display("FAIL drain: got %0d checks still pending, expected 0", q_at.size());
            q_at.delete();
            q_name.delete();
            q_exp.delete();
        end
    endtask

    task automatic do_reset(input logic a1, input logic a2, input logic a3, input logic sv);
        reset = 1'b0;
        p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
        f1 = a1; f2 = a2; f3 = a3; s = sv;
        tick(3);
        expect_out("reset_state", 0, 1'b0, 1'b0, SEG_DASH, 4'b0000);
        tick(1);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(1);

        // Overloaded at floor 1: every call ignored, led[2] follows s
        do_reset(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("ovl_init", 1, 1'b0, 1'b0, SEG_ONE, 4'b0100);
        tick(2);
        p1 = 1'b1; expect_out("ovl_p1", 3, 1'b0, 1'b0, SEG_ONE, 4'b0100);
        tick(4);
        p1 = 1'b0; p2 = 1'b1; expect_out("ovl_p2", 3, 1'b0, 1'b0, SEG_ONE, 4'b0100);
        tick(4);
        p2 = 1'b0; p3 = 1'b1; expect_out("ovl_p3", 3, 1'b0, 1'b0, SEG_ONE, 4'b0100);
        tick(4);
        p3 = 1'b0;
        tick(2);
        s = 1'b0; expect_out("ovl_release_lost", 3, 1'b0, 1'b0, SEG_ONE, 4'b0000);
        drain();

        // Floor 1 to 2, floor 3 sensor overshoots the target
        do_reset(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("f1_init", 1, 1'b0, 1'b0, SEG_ONE, 4'b0000);
        tick(2);
        p2 = 1'b1; expect_out("up_start", 3, 1'b1, 1'b0, SEG_ONE, 4'b0001);
        tick(1);
        p2 = 1'b0;
        tick(3);
        f1 = 1'b0; f3 = 1'b1; expect_out("up_beyond_fault", 3, 1'b0, 1'b0, SEG_E, 4'b1000);
        tick(10);
        p1 = 1'b1; s = 1'b1; f1 = 1'b1; expect_out("fault_hold", 3, 1'b0, 1'b0, SEG_E, 4'b1100);
        tick(6);
        expect_out("fault_hold_late", 0, 1'b0, 1'b0, SEG_E, 4'b1100);
        drain();

        // No sensor at start: descend to floor 1, then a stray floor 2 sensor
        do_reset(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("unk_init", 1, 1'b0, 1'b0, SEG_DASH, 4'b0000);
        tick(2);
        p1 = 1'b1; expect_out("unk_down", 3, 1'b0, 1'b1, SEG_DASH, 4'b0010);
        tick(1);
        p1 = 1'b0;
        tick(3);
        f1 = 1'b1; expect_out("unk_arrive", 3, 1'b0, 1'b0, SEG_ONE, 4'b0000);
        tick(4);
        f2 = 1'b1; expect_out("idle_stray_fault", 3, 1'b0, 1'b0, SEG_E, 4'b1000);
        drain();

        // Floor 3 to 2, floor 1 sensor overshoots the target
        do_reset(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("f3_init", 1, 1'b0, 1'b0, SEG_THREE, 4'b0000);
        tick(2);
        p2 = 1'b1; expect_out("down_start", 3, 1'b0, 1'b1, SEG_THREE, 4'b0010);
        tick(1);
        p2 = 1'b0;
        tick(3);
        f3 = 1'b0; f1 = 1'b1; expect_out("down_beyond_fault", 3, 1'b0, 1'b0, SEG_E, 4'b1000);
        drain();

        // Idle at floor 2: sensor drop tolerated, foreign sensor faults, async reset
        do_reset(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("f2_init", 1, 1'b0, 1'b0, SEG_TWO, 4'b0000);
        tick(2);
        f2 = 1'b0; expect_out("idle_drop_ok", 3, 1'b0, 1'b0, SEG_TWO, 4'b0000);
        tick(4);
        f1 = 1'b1; expect_out("idle_other_fault", 3, 1'b0, 1'b0, SEG_E, 4'b1000);
        tick(5);
        reset = 1'b0; expect_out("async_reset", 0, 1'b0, 1'b0, SEG_DASH, 4'b0000);
        drain();

        // Floor 1 to 3 passing floor 2; same-floor call ignored first
        do_reset(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("trip_init", 1, 1'b0, 1'b0, SEG_ONE, 4'b0000);
        tick(2);
        p1 = 1'b1; expect_out("same_floor_ignored", 3, 1'b0, 1'b0, SEG_ONE, 4'b0000);
        tick(1);
        p1 = 1'b0;
        tick(3);
        p3 = 1'b1; expect_out("trip_start", 3, 1'b1, 1'b0, SEG_ONE, 4'b0001);
        tick(1);
        p3 = 1'b0;
        tick(3);
        f1 = 1'b0; f2 = 1'b1; expect_out("trip_pass2", 3, 1'b1, 1'b0, SEG_TWO, 4'b0001);
        tick(4);
        f2 = 1'b0; f3 = 1'b1; expect_out("trip_arrive", 3, 1'b0, 1'b0, SEG_THREE, 4'b0000);
        drain();

        // Target never reached: fault after TIMEOUT cycles of motion
        do_reset(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("to_init", 1, 1'b0, 1'b0, SEG_ONE, 4'b0000);
        tick(2);
        p3 = 1'b1;
        expect_out("to_start", 3, 1'b1, 1'b0, SEG_ONE, 4'b0001);
        expect_out("to_last_moving", 3 + TIMEOUT - 1, 1'b1, 1'b0, SEG_ONE, 4'b0001);
        expect_out("to_fault", 3 + TIMEOUT, 1'b0, 1'b0, SEG_E, 4'b1000);
        tick(1);
        p3 = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
